// File: rtl/acc_sequencer.sv
// Accumulator sequencer: accepts one LOAD/ADD/SUB/CLEAR command at a time through a
// ready/valid handshake, updates the accumulator and NZCV-style flags one cycle later,
// and holds the result until the consumer takes it.
module acc_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] acc,
    output logic             c,
    output logic             v,
    output logic             z,
    output logic             n
);

    localparam int unsigned Msb = WIDTH - 1;

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpAdd   = 2'b01;
    localparam logic [1:0] OpSub   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic [WIDTH:0]   sum_w;
    logic             accept;

    // Handshake outputs; cmd_ready is gated by rst so it is low throughout reset.
    always_comb begin
        cmd_ready = (state_q == StIdle) && !rst;
        res_valid = (state_q == StDone);
        accept    = cmd_valid && cmd_ready;
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> DONE always, DONE -> IDLE on res_ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StDone;
            StDone:  if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch; only written on an accepted command so later bus activity is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OpLoad;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
        end
    end

    // Datapath: new accumulator and flags for the latched opcode. SUB is acc + ~op + 1,
    // so c = 1 means no borrow.
    always_comb begin
        acc_d = acc_q;
        c_d   = c_q;
        v_d   = v_q;
        sum_w = '0;
        unique case (op_q)
            OpLoad: begin
                acc_d = data_q;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end
            OpAdd: begin
                sum_w = {1'b0, acc_q} + {1'b0, data_q};
                acc_d = sum_w[WIDTH-1:0];
                c_d   = sum_w[WIDTH];
                v_d   = (acc_q[Msb] == data_q[Msb]) && (sum_w[Msb] != acc_q[Msb]);
            end
            OpSub: begin
                sum_w = {1'b0, acc_q} + {1'b0, ~data_q} + {{WIDTH{1'b0}}, 1'b1};
                acc_d = sum_w[WIDTH-1:0];
                c_d   = sum_w[WIDTH];
                v_d   = (acc_q[Msb] != data_q[Msb]) && (sum_w[Msb] != acc_q[Msb]);
            end
            OpClear: begin
                acc_d = '0;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
        z_d = (acc_d == '0);
        n_d = acc_d[Msb];
    end

    // Result registers: written only on the EXEC -> DONE edge, so they persist otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            z_q   <= 1'b1;
            n_q   <= 1'b0;
        end else if (state_q == StExec) begin
            acc_q <= acc_d;
            c_q   <= c_d;
            v_q   <= v_d;
            z_q   <= z_d;
            n_q   <= n_d;
        end
    end

    // Output drive.
    always_comb begin
        acc = acc_q;
        c   = c_q;
        v   = v_q;
        z   = z_q;
        n   = n_q;
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: directed vector table, hand-written hold and reset sequences,
// then random commands compared against an arithmetic reference model.
module tb_acc_sequencer;

    localparam int W    = 4;
    localparam int Full = 1 << W;
    localparam int Half = 1 << (W - 1);

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SUB = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] acc;
    logic         c, v, z, n;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    int m_acc;
    bit m_c, m_v;

    acc_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .acc       (acc),
        .c         (c),
        .v         (v),
        .z         (z),
        .n         (n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] data;
        int           hold;
        logic [W+3:0] exp;   // {acc, c, v, z, n}
    } vec_t;

    function automatic logic [W+3:0] pack(input int a, input bit cc, input bit vv);
        logic [W-1:0] a4;
        a4 = a[W-1:0];
        return {a4, cc, vv, (a == 0), (a >= Half)};
    endfunction

    function automatic int sx(input int x);
        return (x >= Half) ? x - Full : x;
    endfunction

    task automatic model_reset();
        m_acc = 0;
        m_c   = 1'b0;
        m_v   = 1'b0;
    endtask

    // Reference: plain integer and signed arithmetic, range checks for carry/overflow.
    task automatic model_step(input logic [1:0] op, input logic [W-1:0] d);
        int a, b, s;
        a = m_acc;
        b = int'(d);
        case (op)
            LD: begin
                m_acc = b; m_c = 0; m_v = 0;
            end
            ADD: begin
                m_acc = (a + b) % Full;
                m_c   = (a + b) >= Full;
                s     = sx(a) + sx(b);
                m_v   = (s > Half - 1) || (s < -Half);
            end
            SUB: begin
                m_acc = (a - b + Full) % Full;
                m_c   = (a >= b);
                s     = sx(a) - sx(b);
                m_v   = (s > Half - 1) || (s < -Half);
            end
            default: begin
                m_acc = 0; m_c = 0; m_v = 0;
            end
        endcase
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] outs();
        return 16'({acc, c, v, z, n});
    endfunction

    // One full command: wait for ready, issue, check EXEC latency, DONE result,
    // `hold` stall cycles in DONE with cmd_valid noise, then return to IDLE.
    task automatic do_cmd(input string name, input logic [1:0] op, input logic [W-1:0] d,
                          input int hold, input logic [W+3:0] exp);
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        check({name, " ready"}, 16'(cmd_ready), 16'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        res_ready = (hold == 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = W'($urandom);
        check({name, " exec res_valid"}, 16'(res_valid), 16'd0);
        @(posedge clk); #1;
        check({name, " done res_valid"}, 16'(res_valid), 16'd1);
        check({name, " result"}, outs(), 16'(exp));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'($urandom);
            @(posedge clk); #1;
            check({name, " hold result"}, outs(), 16'(exp));
            check({name, " hold ready/valid"}, 16'({cmd_ready, res_valid}), 16'b01);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check({name, " idle ready/valid"}, 16'({cmd_ready, res_valid}), 16'b10);
        check({name, " idle result"}, outs(), 16'(exp));
    endtask

    vec_t vecs[$];

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        res_ready = 1'b0;
        model_reset();

        vecs.push_back('{LD,  4'h7, 0, pack(7, 0, 0)});
        vecs.push_back('{ADD, 4'h1, 0, pack(8, 0, 1)});
        vecs.push_back('{SUB, 4'h8, 0, pack(0, 1, 0)});
        vecs.push_back('{SUB, 4'h1, 0, pack(15, 0, 0)});
        vecs.push_back('{LD,  4'hF, 0, pack(15, 0, 0)});
        vecs.push_back('{ADD, 4'h1, 0, pack(0, 1, 0)});
        vecs.push_back('{LD,  4'h5, 5, pack(5, 0, 0)});
        vecs.push_back('{CLR, 4'h9, 0, pack(0, 0, 0)});
        vecs.push_back('{SUB, 4'h8, 2, pack(8, 0, 1)});
        vecs.push_back('{ADD, 4'h8, 0, pack(0, 1, 1)});

        // Reset state while rst is held.
        #1;
        check("reset outputs", outs(), 16'(pack(0, 0, 0)));
        check("reset ready/valid", 16'({cmd_ready, res_valid}), 16'b00);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("ready after reset", 16'(cmd_ready), 16'd1);

        // Directed table.
        foreach (vecs[i]) begin
            model_step(vecs[i].op, vecs[i].data);
            do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].hold,
                   vecs[i].exp);
        end

        // Reset between edges while a command is in EXEC.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = LD;
        cmd_data  = 4'h9;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid-exec reset outputs", outs(), 16'(pack(0, 0, 0)));
        check("mid-exec reset ready/valid", 16'({cmd_ready, res_valid}), 16'b00);
        @(posedge clk); #1;
        check("held reset outputs", outs(), 16'(pack(0, 0, 0)));
        rst = 1'b0;
        model_reset();
        #1;
        check("ready after mid reset", 16'(cmd_ready), 16'd1);
        model_step(LD, 4'h3);
        do_cmd("load after reset", LD, 4'h3, 0, pack(3, 0, 0));

        // Random commands against the model.
        for (int i = 0; i < 60; i++) begin
            logic [1:0]   op;
            logic [W-1:0] d;
            int           h;
            op = 2'($urandom_range(0, 3));
            d  = W'($urandom);
            h  = $urandom_range(0, 2);
            model_step(op, d);
            do_cmd($sformatf("rnd%0d op%0d d%0h", i, op, d), op, d, h,
                   pack(m_acc, m_c, m_v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
